seq_shift_unit: RTL and testbench

Multi-mode iterative shifter, parametrised successor to the fixed single-bit ALU shift unit. Shifts a selected operand (A or B) by a runtime amount, STEP bits per cycle. Supports logical, arithmetic and rotate modes. Sits in the ALU beside the arithmetic/logic units; the ALU decoder drives the start/done handshake and the busy stall.

---
 rtl/seq_shift_pkg.sv | 30 +++
 rtl/seq_shift_unit_step_dp.sv | 66 ++++++
 rtl/seq_shift_unit.sv | 155 +++++++++++++++
 tb/tb_seq_shift_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_pkg.sv
// Shared definitions for the iterative shifter: op codes, FSM states, count helper.
package seq_shift_pkg;

  localparam logic [2:0] OP_LSR = 3'b000;
  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True for the five defined shift/rotate codes.
  function automatic logic op_is_legal(logic [2:0] op);
    return (op <= OP_ROL);
  endfunction

  // Initial remaining count: clamped for shifts, modulo operand width for rotates.
  function automatic int unsigned init_count(logic [2:0] op, int unsigned amt,
                                             int unsigned out_w, int unsigned w);
    case (op)
      OP_LSR, OP_LSL, OP_ASR: return (amt > out_w) ? out_w : amt;
      OP_ROR, OP_ROL:         return amt & (w - 1);
      default:                return 0;
    endcase
  endfunction

endpackage

// File: rtl/seq_shift_unit_step_dp.sv
// Combinational single-step datapath: shifts/rotates the working register by s bits
// and reports the last bit that left (or wrapped around) the field.
module shift_step_dp
  import seq_shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic [OUT_WIDTH-1:0] cur,
  input  logic [2:0]           op,
  input  logic [CNT_W-1:0]     s,
  output logic [OUT_WIDTH-1:0] nxt,
  output logic                 out_bit
);

  logic [OUT_WIDTH-1:0] tmp;
  logic [WIDTH-1:0]     lo;
  logic [WIDTH-1:0]     lo_rot;
  logic [WIDTH-1:0]     lo_tmp;
  int unsigned          sh;

  // One step of the selected operation; rotates confine themselves to the low WIDTH bits.
  always_comb begin
    sh      = 32'(s);
    lo      = cur[WIDTH-1:0];
    nxt     = cur;
    out_bit = 1'b0;
    tmp     = '0;
    lo_rot  = '0;
    lo_tmp  = '0;
    if (sh != 0) begin
      case (op)
        OP_LSR: begin
          nxt     = cur >> sh;
          tmp     = cur >> (sh - 1);
          out_bit = tmp[0];
        end
        OP_LSL: begin
          nxt     = cur << sh;
          tmp     = cur >> (OUT_WIDTH - sh);
          out_bit = tmp[0];
        end
        OP_ASR: begin
          nxt     = OUT_WIDTH'($signed(cur) >>> sh);
          tmp     = cur >> (sh - 1);
          out_bit = tmp[0];
        end
        OP_ROR: begin
          lo_rot  = (lo >> sh) | (lo << (WIDTH - sh));
          nxt     = OUT_WIDTH'(lo_rot);
          lo_tmp  = lo >> (sh - 1);
          out_bit = lo_tmp[0];
        end
        OP_ROL: begin
          lo_rot  = (lo << sh) | (lo >> (WIDTH - sh));
          nxt     = OUT_WIDTH'(lo_rot);
          lo_tmp  = lo >> (WIDTH - sh);
          out_bit = lo_tmp[0];
        end
        default: nxt = '0;
      endcase
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-mode iterative shifter (LSR/LSL/ASR/ROR/ROL), STEP bits per cycle,
// start/done handshake with Busy stall and synchronous Kill.
// Optional feature macro: SHIFT_CARRY_EN adds the Carry_OUT port and carry register.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHAMT_W   = 5,
  parameter int unsigned STEP      = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 Op_Sel,
  input  logic [2:0]           ALU_FUN,
  input  logic [SHAMT_W-1:0]   Shift_Amt,
  input  logic                 Shift_Enable,
  input  logic                 Kill,
  output logic                 Busy,
  output logic [OUT_WIDTH-1:0] Shift_OUT,
  output logic                 Shift_Flag
`ifdef SHIFT_CARRY_EN
  ,
  output logic                 Carry_OUT
`endif
);

  localparam int unsigned      CNT_W  = $clog2(OUT_WIDTH + 1);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  state_e               state_q, state_d;
  logic [OUT_WIDTH-1:0] work_q, work_d;
  logic [2:0]           op_q, op_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]     step_s;
  logic                 busy_d;
  logic [OUT_WIDTH-1:0] out_d;
  logic                 flag_d;
  logic [WIDTH-1:0]     operand;
  logic [OUT_WIDTH-1:0] dp_next;
  logic                 dp_bit;
`ifdef SHIFT_CARRY_EN
  logic                 cacc_q, cacc_d;
  logic                 carry_d;
`else
  logic                 unused_dp_bit;
  assign unused_dp_bit = dp_bit;
`endif

  // Bits to move this cycle: never more than STEP, never more than what remains.
  assign step_s  = (rem_q > STEP_C) ? STEP_C : rem_q;
  assign operand = Op_Sel ? B : A;

  shift_step_dp #(
    .WIDTH    (WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .CNT_W    (CNT_W)
  ) u_step (
    .cur    (work_q),
    .op     (op_q),
    .s      (step_s),
    .nxt    (dp_next),
    .out_bit(dp_bit)
  );

  // Next-state and next-output logic for the load / shift / complete sequence.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    rem_d   = rem_q;
    out_d   = Shift_OUT;
    flag_d  = 1'b0;
`ifdef SHIFT_CARRY_EN
    cacc_d  = cacc_q;
    carry_d = Carry_OUT;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Shift_Enable) begin
          op_d  = ALU_FUN;
          rem_d = CNT_W'(init_count(ALU_FUN, 32'(Shift_Amt), OUT_WIDTH, WIDTH));
          if (!op_is_legal(ALU_FUN)) begin
            work_d = '0;
          end else if (ALU_FUN == OP_ASR) begin
            work_d = OUT_WIDTH'($signed(operand));
          end else begin
            work_d = OUT_WIDTH'(operand);
          end
`ifdef SHIFT_CARRY_EN
          cacc_d = 1'b0;
`endif
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (Kill) begin
          state_d = ST_IDLE;
        end else if (rem_q == '0) begin
          out_d   = work_q;
          flag_d  = 1'b1;
`ifdef SHIFT_CARRY_EN
          carry_d = cacc_q;
`endif
          state_d = ST_IDLE;
        end else begin
          work_d = dp_next;
          rem_d  = rem_q - step_s;
`ifdef SHIFT_CARRY_EN
          cacc_d = dp_bit;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      op_q       <= OP_LSR;
      rem_q      <= '0;
      Busy       <= 1'b0;
      Shift_OUT  <= '0;
      Shift_Flag <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      Busy       <= busy_d;
      Shift_OUT  <= out_d;
      Shift_Flag <= flag_d;
    end
  end

`ifdef SHIFT_CARRY_EN
  // Running last-out bit and the carry published on completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cacc_q    <= 1'b0;
      Carry_OUT <= 1'b0;
    end else begin
      cacc_q    <= cacc_d;
      Carry_OUT <= carry_d;
    end
  end
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: two instances (STEP=1 and STEP=2) share
// stimulus and are checked every cycle against a whole-value behavioural model.
module tb_seq_shift_unit;

  logic        CLK;
  logic        RST;
  logic [7:0]  A, B;
  logic        Op_Sel;
  logic [2:0]  ALU_FUN;
  logic [4:0]  Shift_Amt;
  logic        Shift_Enable;
  logic        Kill;

  logic        d_busy [2];
  logic [15:0] d_out  [2];
  logic        d_flag [2];
  logic        d_carry[2];

  int errors = 0;
  int checks = 0;
  logic check_on = 1'b0;
  localparam int STEPS [2] = '{1, 2};

  seq_shift_unit #(.WIDTH(8), .OUT_WIDTH(16), .SHAMT_W(5), .STEP(1)) dut1 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .Op_Sel(Op_Sel), .ALU_FUN(ALU_FUN),
    .Shift_Amt(Shift_Amt), .Shift_Enable(Shift_Enable), .Kill(Kill),
    .Busy(d_busy[0]), .Shift_OUT(d_out[0]), .Shift_Flag(d_flag[0])
`ifdef SHIFT_CARRY_EN
    , .Carry_OUT(d_carry[0])
`endif
  );

  seq_shift_unit #(.WIDTH(8), .OUT_WIDTH(16), .SHAMT_W(5), .STEP(2)) dut2 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .Op_Sel(Op_Sel), .ALU_FUN(ALU_FUN),
    .Shift_Amt(Shift_Amt), .Shift_Enable(Shift_Enable), .Kill(Kill),
    .Busy(d_busy[1]), .Shift_OUT(d_out[1]), .Shift_Flag(d_flag[1])
`ifdef SHIFT_CARRY_EN
    , .Carry_OUT(d_carry[1])
`endif
  );

`ifndef SHIFT_CARRY_EN
  assign d_carry[0] = 1'b0;
  assign d_carry[1] = 1'b0;
`endif

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Whole-result reference: {carry, result} computed in one go from the op rules.
  function automatic logic [16:0] ref_shift(logic [2:0] fn, logic [7:0] v, logic [4:0] amt);
    logic [15:0] ext;
    logic [31:0] w;
    logic [15:0] d;
    int n;
    ext = {8'h00, v};
    case (fn)
      3'd0: begin
        n = (amt > 16) ? 16 : int'(amt);
        w = {ext, 16'h0} >> n;
        return {(n != 0) & w[15], w[31:16]};
      end
      3'd1: begin
        n = (amt > 16) ? 16 : int'(amt);
        w = {16'h0, ext} << n;
        return {(n != 0) & w[16], w[15:0]};
      end
      3'd2: begin
        n = (amt > 16) ? 16 : int'(amt);
        ext = {{8{v[7]}}, v};
        w = $signed({ext, 16'h0}) >>> n;
        return {(n != 0) & w[15], w[31:16]};
      end
      3'd3: begin
        n = int'(amt) % 8;
        d = {v, v} >> n;
        return {(n != 0) & d[7], 8'h00, d[7:0]};
      end
      3'd4: begin
        n = int'(amt) % 8;
        d = {v, v} << n;
        return {(n != 0) & d[8], 8'h00, d[15:8]};
      end
      default: return 17'h0;
    endcase
  endfunction

  function automatic int ref_count(logic [2:0] fn, logic [4:0] amt);
    if (fn <= 3'd2) return (amt > 16) ? 16 : int'(amt);
    if (fn <= 3'd4) return int'(amt) % 8;
    return 0;
  endfunction

  // Behavioural model: each job finishes ceil(count/STEP)+1 edges after its start edge.
  logic        m_busy [2];
  int          m_left [2];
  logic [15:0] m_res  [2];
  logic        m_cres [2];
  logic [15:0] m_out  [2];
  logic        m_flag [2];
  logic        m_carry[2];

  always @(posedge CLK or posedge RST) begin
    logic [16:0] rc;
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_left[i] <= 0; m_res[i] <= '0; m_cres[i] <= 1'b0;
        m_out[i] <= '0; m_flag[i] <= 1'b0; m_carry[i] <= 1'b0;
      end
    end else begin
      rc = ref_shift(ALU_FUN, Op_Sel ? B : A, Shift_Amt);
      for (int i = 0; i < 2; i++) begin
        m_flag[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (Shift_Enable) begin
            m_busy[i] <= 1'b1;
            m_res[i]  <= rc[15:0];
            m_cres[i] <= rc[16];
            m_left[i] <= (ref_count(ALU_FUN, Shift_Amt) + STEPS[i] - 1) / STEPS[i] + 1;
          end
        end else if (Kill) begin
          m_busy[i] <= 1'b0;
        end else if (m_left[i] == 1) begin
          m_busy[i]  <= 1'b0;
          m_flag[i]  <= 1'b1;
          m_out[i]   <= m_res[i];
          m_carry[i] <= m_cres[i];
        end else begin
          m_left[i] <= m_left[i] - 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (check_on && !RST) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc busy%0d", i), 32'(d_busy[i]), 32'(m_busy[i]));
        chk($sformatf("cyc flag%0d", i), 32'(d_flag[i]), 32'(m_flag[i]));
        chk($sformatf("cyc out%0d", i), 32'(d_out[i]), 32'(m_out[i]));
`ifdef SHIFT_CARRY_EN
        chk($sformatf("cyc carry%0d", i), 32'(d_carry[i]), 32'(m_carry[i]));
`endif
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 40 && (d_busy[0] || d_busy[1]); k++) @(posedge CLK) #1;
    chk("idle bound", 32'(d_busy[0] | d_busy[1]), 32'd0);
  endtask

  // Start one job, optionally pulse a second start or a Kill at edge E0+k, watch 24 edges.
  task automatic run_op(input string nm, input logic [2:0] fn, input logic sel,
                        input logic [7:0] a, input logic [7:0] b, input logic [4:0] amt,
                        input int pulse_k, input int kill_k, input logic [15:0] exp_v,
                        input int exp_l0, input int exp_l1, input logic exp_c);
    int lat[2];
    int cnt[2];
    int exp_l[2];
    exp_l = '{exp_l0, exp_l1};
    lat = '{-1, -1};
    cnt = '{0, 0};
    wait_idle();
    @(negedge CLK);
    ALU_FUN = fn; Op_Sel = sel; A = a; B = b; Shift_Amt = amt;
    Shift_Enable = 1'b1; Kill = 1'b0;
    @(posedge CLK);
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      Shift_Enable = (k == pulse_k);
      Kill = (k == kill_k);
      if (k == pulse_k) begin
        A = ~a; B = ~b; ALU_FUN = 3'd4; Shift_Amt = 5'd1;
      end
      @(posedge CLK) #1;
      for (int i = 0; i < 2; i++) begin
        if (d_flag[i]) begin
          cnt[i]++;
          if (lat[i] < 0) lat[i] = k;
        end
      end
    end
    @(negedge CLK);
    Shift_Enable = 1'b0; Kill = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s latency%0d", nm, i), 32'(lat[i]), 32'(exp_l[i]));
      chk($sformatf("%s flags%0d", nm, i), 32'(cnt[i]), (exp_l[i] > 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s value%0d", nm, i), 32'(d_out[i]), 32'(exp_v));
`ifdef SHIFT_CARRY_EN
      chk($sformatf("%s carry%0d", nm, i), 32'(d_carry[i]), 32'(exp_c));
`endif
    end
  endtask

  initial begin
    RST = 1'b0; A = '0; B = '0; Op_Sel = 1'b0; ALU_FUN = '0; Shift_Amt = '0;
    Shift_Enable = 1'b0; Kill = 1'b0;

    chk("pin lsl", 32'(ref_shift(3'd1, 8'h81, 5'd1)), 32'h00102);
    chk("pin asr", 32'(ref_shift(3'd2, 8'h90, 5'd3)), 32'h0FFF2);
    chk("pin ror", 32'(ref_shift(3'd3, 8'h01, 5'd9)), 32'h10080);
    chk("pin rol", 32'(ref_shift(3'd4, 8'h80, 5'd1)), 32'h10001);
    chk("pin lsr", 32'(ref_shift(3'd0, 8'hFF, 5'd31)), 32'h00000);
    chk("pin cnt", 32'(ref_count(3'd0, 5'd31)), 32'd16);

    #1 RST = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset busy%0d", i), 32'(d_busy[i]), 32'd0);
      chk($sformatf("reset out%0d", i), 32'(d_out[i]), 32'd0);
      chk($sformatf("reset flag%0d", i), 32'(d_flag[i]), 32'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    check_on = 1'b1;

    run_op("lsl81",   3'd1, 1'b0, 8'h81, 8'h00, 5'd1,  0, 0, 16'h0102, 2, 2, 1'b0);
    run_op("asr90",   3'd2, 1'b1, 8'h11, 8'h90, 5'd3,  0, 0, 16'hFFF2, 4, 3, 1'b0);
    run_op("ror9",    3'd3, 1'b0, 8'h01, 8'h00, 5'd9,  0, 0, 16'h0080, 2, 2, 1'b1);
    run_op("rol1",    3'd4, 1'b0, 8'h80, 8'h00, 5'd1,  0, 0, 16'h0001, 2, 2, 1'b1);
    run_op("lsr31",   3'd0, 1'b0, 8'hFF, 8'h00, 5'd31, 0, 0, 16'h0000, 17, 9, 1'b0);
    run_op("lsl0",    3'd1, 1'b0, 8'h5A, 8'h00, 5'd0,  0, 0, 16'h005A, 1, 1, 1'b0);
    run_op("illegal", 3'd6, 1'b0, 8'hFF, 8'hFF, 5'd7,  0, 0, 16'h0000, 1, 1, 1'b0);
    run_op("busyign", 3'd1, 1'b0, 8'h03, 8'h00, 5'd5,  2, 0, 16'h0060, 6, 4, 1'b0);
    run_op("kill",    3'd1, 1'b0, 8'h05, 8'h00, 5'd5,  0, 2, 16'h0060, -1, -1, 1'b0);

    // Asynchronous reset in the middle of a long job.
    wait_idle();
    @(negedge CLK);
    ALU_FUN = 3'd0; A = 8'hF0; Shift_Amt = 5'd10; Op_Sel = 1'b0; Shift_Enable = 1'b1;
    @(negedge CLK);
    Shift_Enable = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst busy%0d", i), 32'(d_busy[i]), 32'd0);
      chk($sformatf("midrst out%0d", i), 32'(d_out[i]), 32'd0);
      chk($sformatf("midrst flag%0d", i), 32'(d_flag[i]), 32'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    run_op("postrst", 3'd1, 1'b0, 8'h81, 8'h00, 5'd1, 0, 0, 16'h0102, 2, 2, 1'b0);

    // Randomized traffic, including starts while busy and occasional kills.
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      Shift_Enable = ($urandom_range(0, 2) == 0);
      Kill         = ($urandom_range(0, 24) == 0);
      A            = 8'($urandom);
      B            = 8'($urandom);
      Op_Sel       = 1'($urandom);
      ALU_FUN      = 3'($urandom_range(0, 7));
      Shift_Amt    = 5'($urandom);
    end
    @(negedge CLK);
    Shift_Enable = 1'b0; Kill = 1'b0;
    wait_idle();
    repeat (2) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
